// File: rtl/irrigation_countdown_ctrl.sv
// Irrigation-duration sequencer: MM:SS BCD countdown with a built-in 1 Hz
// prescaler, pause/resume, abort, and valve/done/preset_err control.
module irrigation_countdown_ctrl #(
    parameter int unsigned DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic [7:0] preset_m,
    input  logic [7:0] preset_s,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       valve,
    output logic       busy,
    output logic       done,
    output logic       preset_err
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    min_t_q, min_t_d;
    logic [3:0]    min_u_q, min_u_d;
    logic [3:0]    sec_t_q, sec_t_d;
    logic [3:0]    sec_u_q, sec_u_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          valve_q, valve_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          tick_c;
    logic          preset_bad_c;
    logic          count_one_c;
    logic [3:0]    dec_min_t_c, dec_min_u_c, dec_sec_t_c, dec_sec_u_c;

    assign tick_c = (presc_q == PW'(DIV - 1));

    assign preset_bad_c = (preset_m[7:4] > 4'd9) || (preset_m[3:0] > 4'd9) ||
                          (preset_s[7:4] > 4'd5) || (preset_s[3:0] > 4'd9) ||
                          ({preset_m, preset_s} == 16'h0000);

    assign count_one_c = ({min_t_q, min_u_q, sec_t_q, sec_u_q} == 16'h0001);

    // One-second decrement with borrow through sec units -> sec tens -> min units -> min tens
    always_comb begin
        logic b_su, b_st, b_mu;
        b_su        = (sec_u_q == 4'd0);
        dec_sec_u_c = b_su ? 4'd9 : sec_u_q - 4'd1;
        b_st        = b_su && (sec_t_q == 4'd0);
        dec_sec_t_c = b_su ? ((sec_t_q == 4'd0) ? 4'd5 : sec_t_q - 4'd1) : sec_t_q;
        b_mu        = b_st && (min_u_q == 4'd0);
        dec_min_u_c = b_st ? ((min_u_q == 4'd0) ? 4'd9 : min_u_q - 4'd1) : min_u_q;
        dec_min_t_c = b_mu ? min_t_q - 4'd1 : min_t_q;
    end

    always_comb begin
        state_d = state_q;
        min_t_d = min_t_q;
        min_u_d = min_u_q;
        sec_t_d = sec_t_q;
        sec_u_d = sec_u_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            min_t_d = 4'd0;
            min_u_d = 4'd0;
            sec_t_d = 4'd0;
            sec_u_d = 4'd0;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (preset_bad_c) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            min_t_d = preset_m[7:4];
                            min_u_d = preset_m[3:0];
                            sec_t_d = preset_s[7:4];
                            sec_u_d = preset_s[3:0];
                            presc_d = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        // Prescaler holds so the sub-second fraction survives the pause
                        state_d = S_PAUSE;
                    end else if (tick_c) begin
                        presc_d = '0;
                        if (count_one_c) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                        min_t_d = dec_min_t_c;
                        min_u_d = dec_min_u_c;
                        sec_t_d = dec_sec_t_c;
                        sec_u_d = dec_sec_u_c;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        valve_d = (state_d == S_RUN);
        busy_d  = (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            min_t_q <= 4'd0;
            min_u_q <= 4'd0;
            sec_t_q <= 4'd0;
            sec_u_q <= 4'd0;
            presc_q <= '0;
            valve_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_t_q <= min_t_d;
            min_u_q <= min_u_d;
            sec_t_q <= sec_t_d;
            sec_u_q <= sec_u_d;
            presc_q <= presc_d;
            valve_q <= valve_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign min_bcd    = {min_t_q, min_u_q};
    assign sec_bcd    = {sec_t_q, sec_u_q};
    assign valve      = valve_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign preset_err = err_q;

endmodule
